ddfs_sweep_ctrl: RTL and testbench
==================================

# ddfs_sweep_ctrl

Frequency-sweep sequencer for the `ddfs` core. It drives the frequency word input `fw` with a linear staircase from a start word to a stop word. Each step is held for a programmable number of clock cycles, in single-shot or continuous mode. It sits between the board-level control (switches and keys, or a host register) and the `ddfs` instance, in the same clock domain as the `ddfs` input clock.

## Interface
- `N`, default 9: frequency-word width; must equal the `ddfs` `N`.
- `DWELL_W`, default 16: dwell counter width.
- `clk` input 1: system clock; the same clock that feeds `ddfs`.
- `rst_n` input 1: reset. One clock; reset is asynchronous and active-low.
- `start` input 1: level-sampled request to begin a sweep; ignored while `busy`=1.
- `abort` input 1: terminates the sweep. Highest priority after reset.
- `cont` input 1: 1 = continuous mode (restart after the stop word); sampled at `start`.
- `fw_start` input N: first frequency word.
- `fw_stop` input N: last frequency word.
- `fw_step` input N: increment per step.
- `dwell` input DWELL_W: each word is held `dwell`+1 cycles.
- `fw_out` output N: frequency word to `ddfs.fw`.
- `busy` output 1: sweep in progress.
- `done` output 1: one-cycle pulse at the end of each sweep pass.

## Operation
- States: IDLE, HOLD, LAST, DONE.
- Reset values: state IDLE, `fw_out`=0, `busy`=0, `done`=0, dwell counter 0.
- **IDLE:**
  - `fw_out` keeps its last value.
  - On `start`=1, the block latches `fw_start`, `fw_stop`, `fw_step`, `dwell` and `cont` into shadow registers.
  - It then sets `fw_out`←`fw_start`, counter←`dwell`, and goes to HOLD.
  - Input changes after this cycle have no effect until the next start.
- **Degenerate start:** if `fw_start`≥`fw_stop`, or `fw_step`=0, the block goes to LAST instead of HOLD. A single word (`fw_start`) is held for one dwell, then DONE.
- **HOLD:**
  - The counter decrements each cycle.
  - When it reaches 0, the next word is computed as `fw_out`+`fw_step` in N+1 bits.
  - If the sum is ≥`fw_stop` (this includes carry-out): `fw_out`←`fw_stop`, counter reloads, go to LAST.
  - Otherwise: `fw_out`←sum, counter reloads, stay in HOLD.
  - Overshoot and wrap are therefore impossible; the stop word is always emitted exactly once per pass.
- **LAST:** the counter decrements each cycle. At 0 the block goes to DONE.
- **DONE:**
  - Asserts `done` for this cycle and deasserts `busy`.
  - If the latched `cont`=1: `fw_out`←latched `fw_start`, counter reloads, go to HOLD (or LAST if the pass is degenerate), and `busy` re-asserts the next cycle.
  - Otherwise go to IDLE, with `fw_out` still holding `fw_stop`.
- **abort**, in any non-IDLE state: next cycle is IDLE with `fw_out`=0, `busy`=0, and no `done` pulse.
  - If `abort` and `start` are both high in IDLE, `abort` wins and `start` is ignored.
- **Reset mid-sweep:** immediate return to the reset values; the shadow registers are cleared.
- Dwell counter is unsigned, and reload always comes from the shadow register.

## Timing
- `start` sampled high at edge t0 gives `fw_out`=`fw_start` and `busy`=1 after t0.
- Each word is visible for exactly `dwell`+1 cycles.
- The stop word is followed by one DONE cycle: `done`=1, `busy`=0, and `fw_out` is still `fw_stop`.
- Sweep latency for K words: `done` appears K·(`dwell`+1) cycles after the first `fw_out` change.
- Continuous mode leaves a one-cycle gap (the DONE cycle) between passes.
- All outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Package `ddfs_pkg`: the state enum (IDLE/HOLD/LAST/DONE) and the default constants `DDFS_N`=9 and `DDFS_DWELL_W`=16, shared with `ddfs`.
- Sub-module `ddfs_dwell_cnt`: a loadable down-counter with a `zero` flag, ports `clk`, `rst_n`, `load`, `load_val`, `en`, `zero`.
- The top level holds the FSM, the shadow registers and the N+1-bit adder/compare.

## Test plan
- Basic sweep: `fw_start`=0x010, `fw_stop`=0x040, `fw_step`=0x010, `dwell`=3, `cont`=0.
  - Required: `fw_out` steps through 0x010, 0x020, 0x030, 0x040, each held 4 cycles.
  - `done` pulses at cycle 17 after `start`; `busy` is low from that cycle.
- Clamp: start 0x000, stop 0x025, step 0x010, dwell 0.
  - Required: `fw_out` is 0x000, 0x010, 0x020, 0x025, then `done`; no value exceeds 0x025.
- Carry-out (N=9): start 0x1F0, stop 0x1FF, step 0x020, dwell 1.
  - Required: 0x1F0 for 2 cycles, then 0x1FF for 2 cycles, then `done`; no wrap to 0x010.
- Degenerate and ignored inputs:
  - start 0x050, stop 0x030 → 0x050 for `dwell`+1 cycles, then `done`.
  - `step`=0 → same single-word behaviour.
  - `start` pulsed while `busy` → ignored.
- Continuous mode and abort: `cont`=1 with the basic sweep values.
  - Required: `done` every 17 cycles, and `fw_out` returns to 0x010 right after each `done`.
  - `abort` at cycle 6 → `fw_out`=0 and `busy`=0 the next cycle, with no `done` pulse.
- Reset mid-sweep: `rst_n` low asynchronously during HOLD.
  - Required: `fw_out`=0, `busy`=0, `done`=0 immediately, before the next clock edge.
  - After release, a new `start` with the basic values reproduces the basic-sweep sequence exactly.

Source files
------------

// File: rtl/ddfs_pkg.sv
// Shared types and default sizes for the ddfs core and its sweep sequencer.
package ddfs_pkg;

  localparam int unsigned DDFS_N       = 9;
  localparam int unsigned DDFS_DWELL_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    LAST,
    DONE
  } sweep_state_e;

endpackage

// File: rtl/ddfs_dwell_cnt.sv
// Loadable down-counter that saturates at zero and flags the zero count.
module ddfs_dwell_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load has priority over decrement; the count never goes below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/ddfs_sweep_ctrl.sv
// Linear frequency-word staircase generator driving ddfs.fw, single-shot or continuous.
module ddfs_sweep_ctrl
  import ddfs_pkg::*;
#(
  parameter int unsigned N       = DDFS_N,
  parameter int unsigned DWELL_W = DDFS_DWELL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               cont,
  input  logic [N-1:0]       fw_start,
  input  logic [N-1:0]       fw_stop,
  input  logic [N-1:0]       fw_step,
  input  logic [DWELL_W-1:0] dwell,
  output logic [N-1:0]       fw_out,
  output logic               busy,
  output logic               done
);

  sweep_state_e state_q;

  logic [N-1:0]       fw_q;
  logic               busy_q;
  logic               done_q;

  logic [N-1:0]       sh_start_q;
  logic [N-1:0]       sh_stop_q;
  logic [N-1:0]       sh_step_q;
  logic [DWELL_W-1:0] sh_dwell_q;
  logic               sh_cont_q;
  logic               sh_degen_q;

  logic [N:0]         sum;
  logic               reach_stop;
  logic               degen_in;

  logic               cnt_load;
  logic [DWELL_W-1:0] cnt_val;
  logic               cnt_en;
  logic               cnt_zero;

  // Extra carry bit makes a wrapped sum compare as past the stop word.
  assign sum        = {1'b0, fw_q} + {1'b0, sh_step_q};
  assign reach_stop = (sum >= {1'b0, sh_stop_q});
  assign degen_in   = (fw_start >= fw_stop) || (fw_step == '0);

  // Dwell counter control: load on each new word, otherwise count down.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = sh_dwell_q;
    cnt_en   = 1'b0;
    if (!abort) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_load = 1'b1;
            cnt_val  = dwell;
          end
        end
        HOLD: begin
          if (cnt_zero) cnt_load = 1'b1;
          else          cnt_en   = 1'b1;
        end
        LAST: begin
          cnt_en = !cnt_zero;
        end
        DONE: begin
          cnt_load = sh_cont_q;
        end
        default: ;
      endcase
    end
  end

  ddfs_dwell_cnt #(
    .W(DWELL_W)
  ) u_dwell_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  // Sweep FSM with shadow registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fw_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sh_start_q <= '0;
      sh_stop_q  <= '0;
      sh_step_q  <= '0;
      sh_dwell_q <= '0;
      sh_cont_q  <= 1'b0;
      sh_degen_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        if (state_q != IDLE) begin
          state_q <= IDLE;
          fw_q    <= '0;
          busy_q  <= 1'b0;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              sh_start_q <= fw_start;
              sh_stop_q  <= fw_stop;
              sh_step_q  <= fw_step;
              sh_dwell_q <= dwell;
              sh_cont_q  <= cont;
              sh_degen_q <= degen_in;
              fw_q       <= fw_start;
              busy_q     <= 1'b1;
              state_q    <= degen_in ? LAST : HOLD;
            end
          end
          HOLD: begin
            if (cnt_zero) begin
              if (reach_stop) begin
                fw_q    <= sh_stop_q;
                state_q <= LAST;
              end else begin
                fw_q <= sum[N-1:0];
              end
            end
          end
          LAST: begin
            if (cnt_zero) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
          DONE: begin
            if (sh_cont_q) begin
              fw_q    <= sh_start_q;
              busy_q  <= 1'b1;
              state_q <= sh_degen_q ? LAST : HOLD;
            end else begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign fw_out = fw_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_ddfs_sweep_ctrl.sv
// Self-checking bench for ddfs_sweep_ctrl: table-driven sweeps plus hand-written corner sequences.
module tb_ddfs_sweep_ctrl;

  localparam int unsigned N  = 9;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          cont = 1'b0;
  logic [N-1:0]  fw_start = '0;
  logic [N-1:0]  fw_stop = '0;
  logic [N-1:0]  fw_step = '0;
  logic [DW-1:0] dwell = '0;
  logic [N-1:0]  fw_out;
  logic          busy;
  logic          done;

  ddfs_sweep_ctrl #(
    .N       (N),
    .DWELL_W (DW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .cont     (cont),
    .fw_start (fw_start),
    .fw_stop  (fw_stop),
    .fw_step  (fw_step),
    .dwell    (dwell),
    .fw_out   (fw_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0] fw;
    logic       busy;
    logic       done;
  } exp_t;

  typedef struct packed {
    logic [8:0]      fs;
    logic [8:0]      fe;
    logic [8:0]      st;
    logic [15:0]     dw;
    logic [2:0]      nw;
    logic [3:0][8:0] w;
  } vec_t;

  localparam exp_t ZERO = '0;

  exp_t sb[$];
  vec_t vecs[6];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input exp_t e);
    n_checks++;
    if (fw_out !== e.fw || busy !== e.busy || done !== e.done) begin
      n_errors++;
      $display("FAIL %s: got fw=%h busy=%b done=%b, want fw=%h busy=%b done=%b",
               name, fw_out, busy, done, e.fw, e.busy, e.done);
    end
  endtask

  // Compare the current outputs against the queue head, then advance one cycle.
  task automatic drain(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s[%0d]: scoreboard empty, got fw=%h", name, i, fw_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("%s[%0d]", name, i), e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Expected outputs for one pass: each word for dwell+1 cycles, then the DONE cycle.
  task automatic push_pass(input vec_t v);
    int last;
    last = int'(v.nw) - 1;
    for (int k = 0; k < int'(v.nw); k++) begin
      for (int c = 0; c <= int'(v.dw); c++) begin
        sb.push_back(exp_t'{fw: v.w[k], busy: 1'b1, done: 1'b0});
      end
    end
    sb.push_back(exp_t'{fw: v.w[last], busy: 1'b0, done: 1'b1});
  endtask

  task automatic load_inputs(input vec_t v);
    fw_start = v.fs;
    fw_stop  = v.fe;
    fw_step  = v.st;
    dwell    = v.dw;
  endtask

  // Single-shot sweep; inputs are scrambled and start kept high while busy.
  task automatic run_vec(input int idx);
    vec_t v;
    int   nbusy;
    v = vecs[idx];
    load_inputs(v);
    cont  = 1'b0;
    start = 1'b1;
    push_pass(v);
    sb.push_back(exp_t'{fw: v.w[int'(v.nw) - 1], busy: 1'b0, done: 1'b0});
    nbusy = int'(v.nw) * (int'(v.dw) + 1);
    @(posedge clk);
    #1;
    fw_start = 9'($urandom);
    fw_stop  = 9'($urandom);
    fw_step  = 9'($urandom);
    dwell    = 16'($urandom_range(0, 7));
    cont     = 1'($urandom);
    drain($sformatf("vec%0d", idx), nbusy);
    start = 1'b0;
    drain($sformatf("vec%0d_end", idx), 2);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{fs: 9'h010, fe: 9'h040, st: 9'h010, dw: 16'd3, nw: 3'd4,
                w: {9'h040, 9'h030, 9'h020, 9'h010}};
    vecs[1] = '{fs: 9'h000, fe: 9'h025, st: 9'h010, dw: 16'd0, nw: 3'd4,
                w: {9'h025, 9'h020, 9'h010, 9'h000}};
    vecs[2] = '{fs: 9'h1F0, fe: 9'h1FF, st: 9'h020, dw: 16'd1, nw: 3'd2,
                w: {18'h0, 9'h1FF, 9'h1F0}};
    vecs[3] = '{fs: 9'h050, fe: 9'h030, st: 9'h010, dw: 16'd2, nw: 3'd1,
                w: {27'h0, 9'h050}};
    vecs[4] = '{fs: 9'h020, fe: 9'h080, st: 9'h000, dw: 16'd1, nw: 3'd1,
                w: {27'h0, 9'h020}};
    vecs[5] = '{fs: 9'h030, fe: 9'h030, st: 9'h010, dw: 16'd0, nw: 3'd1,
                w: {27'h0, 9'h030}};

    // Reset values while reset is held, and right after release.
    #12;
    check("reset", ZERO);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_idle", ZERO);

    for (int i = 0; i < 6; i++) begin
      run_vec(i);
    end

    // Continuous mode: two full passes, then abort partway into the third.
    load_inputs(vecs[0]);
    cont  = 1'b1;
    start = 1'b1;
    push_pass(vecs[0]);
    push_pass(vecs[0]);
    for (int i = 0; i < 4; i++) sb.push_back(exp_t'{fw: 9'h010, busy: 1'b1, done: 1'b0});
    for (int i = 0; i < 3; i++) sb.push_back(exp_t'{fw: 9'h020, busy: 1'b1, done: 1'b0});
    @(posedge clk);
    #1;
    start = 1'b0;
    cont  = 1'b0;
    drain("cont", 40);
    abort = 1'b1;
    drain("cont_abort", 1);
    for (int i = 0; i < 3; i++) sb.push_back(ZERO);
    drain("aborted", 1);
    start = 1'b1;
    drain("abort_start_idle", 1);
    start = 1'b0;
    abort = 1'b0;
    drain("idle_after_abort", 1);

    // Asynchronous reset in the middle of HOLD.
    load_inputs(vecs[0]);
    cont  = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", ZERO);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("after_reset", ZERO);
    run_vec(0);

    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_leftover: got %0d entries, want 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
